// File: rtl/wb_cmd_master_if.sv
// Command/response handshake and Wishbone classic bus signals of wb_cmd_master.
// Signal suffixes are written from the master's point of view.
interface wb_cmd_master_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_we_i;
    logic [AW-1:0] cmd_adr_i;
    logic [DW-1:0] cmd_dat_i;
    logic [SW-1:0] cmd_sel_i;

    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_dat_o;
    logic          rsp_err_o;

    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [SW-1:0] wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_ack_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  rsp_ready_i,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        output rsp_ready_i,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one valid/ready command becomes one
// cyc/stb cycle, answered by a valid/ready response carrying read data or a timeout error.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    wb_cmd_master_if.master        bus,
    output logic                   busy_o
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_dat_q, rsp_dat_d;
    logic          rsp_err_q, rsp_err_d;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    we_d    = bus.cmd_we_i;
                    sel_d   = bus.cmd_sel_i;
                    adr_d   = bus.cmd_adr_i;
                    dat_d   = bus.cmd_dat_i;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                // Ack takes priority over a timeout expiring in the same cycle.
                if (bus.wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = we_q ? '0 : bus.wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cmd_ready_o = (state_q == S_IDLE);
    assign busy_o          = (state_q != S_IDLE);
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_dat_o   = rsp_dat_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.wbm_cyc_o   = cyc_q;
    assign bus.wbm_stb_o   = cyc_q;
    assign bus.wbm_we_o    = we_q;
    assign bus.wbm_sel_o   = sel_q;
    assign bus.wbm_adr_o   = adr_q;
    assign bus.wbm_dat_o   = dat_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a hand-driven Wishbone slave and TIMEOUT=4.
module tb_wb_cmd_master;
    logic clk;
    logic rst;
    logic busy;
    int   errors;
    int   checks;

    wb_cmd_master_if bus ();

    wb_cmd_master #(.TIMEOUT(4), .TO_W(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus),
        .busy_o   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and wait (bounded) for its acceptance edge.
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        logic rdy;
        bit   ok;
        ok = 1'b0;
        bus.cmd_we_i    = we;
        bus.cmd_adr_i   = adr;
        bus.cmd_dat_i   = dat;
        bus.cmd_sel_i   = sel;
        bus.cmd_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rdy = bus.cmd_ready_o;
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        bus.cmd_valid_i = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL issue_accept: got not accepted expected accepted adr=%h", adr);
        end
    endtask

    // Slave acking on its ack_at-th strobe cycle (0 = never); n returns strobe cycles seen.
    task automatic run_bus(input int ack_at, input logic [31:0] rdata, output int n);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (!bus.wbm_stb_o) break;
            n++;
            bus.wbm_ack_i = (ack_at != 0 && n == ack_at);
            bus.wbm_dat_i = (ack_at != 0 && n == ack_at) ? rdata : 32'h0BAD_0BAD;
            tick();
        end
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o});
        end
        checks++;
        if ({bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o} !== 68'h0) begin
            errors++;
            $display("FAIL reset_fields: got %h expected 0", {bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o});
        end
        checks++;
        if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o} !== 34'h0) begin
            errors++;
            $display("FAIL reset_rsp: got %h expected 0", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.cmd_ready_o, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_idle: got ready/busy=%b expected 10", {bus.cmd_ready_o, busy});
        end
    endtask

    task automatic test_read_zero_wait();
        int n;
        bus.rsp_ready_i = 1'b1;
        issue(1'b0, 32'h0000_1000, 32'h0, 4'hF);
        checks++;
        if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, busy, bus.cmd_ready_o} !== 5'b11010) begin
            errors++;
            $display("FAIL rd_bus_state: got %b expected 11010",
                     {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, busy, bus.cmd_ready_o});
        end
        run_bus(1, 32'hDEAD_BEEF, n);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL rd_stb_cycles: got %0d expected 1", n);
        end
        checks++;
        if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o} !== {2'b10, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL rd_rsp: got v/e/d=%b%b %h expected 10 deadbeef",
                     bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o);
        end
        tick();
        checks++;
        if ({bus.rsp_valid_o, bus.cmd_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL rd_rsp_one_cycle: got valid/ready=%b expected 01", {bus.rsp_valid_o, bus.cmd_ready_o});
        end
    endtask

    task automatic test_write_wait();
        int n;
        bit stable;
        stable = 1'b1;
        n = 0;
        bus.rsp_ready_i = 1'b0;
        issue(1'b1, 32'h3000_0004, 32'h1234_5678, 4'b0011);
        for (int c = 0; c < 40; c++) begin
            if (!bus.wbm_stb_o) break;
            n++;
            if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_we_o !== 1'b1 || bus.wbm_adr_o !== 32'h3000_0004 ||
                bus.wbm_dat_o !== 32'h1234_5678 || bus.wbm_sel_o !== 4'b0011)
                stable = 1'b0;
            bus.wbm_ack_i = (n == 4);
            bus.wbm_dat_i = 32'hFFFF_FFFF;
            tick();
        end
        bus.wbm_ack_i = 1'b0;
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL wr_stb_cycles: got %0d expected 4", n);
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL wr_fields_stable: got unstable expected stable");
        end
        checks++;
        if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o} !== {2'b10, 32'h0}) begin
            errors++;
            $display("FAIL wr_rsp: got v/e/d=%b%b %h expected 10 00000000",
                     bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o);
        end
        checks++;
        if ({bus.wbm_adr_o, bus.wbm_sel_o} !== {32'h3000_0004, 4'b0011}) begin
            errors++;
            $display("FAIL wr_fields_kept: got %h %b expected 30000004 0011", bus.wbm_adr_o, bus.wbm_sel_o);
        end
        bus.rsp_ready_i = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        issue(1'b0, 32'h0000_2000, 32'h0, 4'hF);
        run_bus(0, 32'h0, n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL to_stb_cycles: got %0d expected 4", n);
        end
        checks++;
        if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o} !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL to_rsp: got v/e/d=%b%b %h expected 11 00000000",
                     bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o);
        end
        tick();
    endtask

    task automatic test_ack_on_timeout();
        int n;
        issue(1'b0, 32'h0000_2004, 32'h0, 4'hF);
        run_bus(4, 32'hA5A5_A5A5, n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL ackto_stb_cycles: got %0d expected 4", n);
        end
        checks++;
        if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o} !== {2'b10, 32'hA5A5_A5A5}) begin
            errors++;
            $display("FAIL ackto_rsp: got v/e/d=%b%b %h expected 10 a5a5a5a5",
                     bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int n;
        bit held;
        held = 1'b1;
        bus.rsp_ready_i = 1'b0;
        issue(1'b0, 32'h0000_0040, 32'h0, 4'hF);
        run_bus(1, 32'h1111_2222, n);
        bus.cmd_we_i    = 1'b1;
        bus.cmd_adr_i   = 32'h0000_2000;
        bus.cmd_dat_i   = 32'h0000_0077;
        bus.cmd_sel_i   = 4'hF;
        bus.cmd_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus.rsp_valid_o !== 1'b1 || bus.rsp_dat_o !== 32'h1111_2222 || bus.rsp_err_o !== 1'b0 ||
                bus.cmd_ready_o !== 1'b0 || bus.wbm_cyc_o !== 1'b0)
                held = 1'b0;
            tick();
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL bp_held: got changed expected rsp held and cmd blocked");
        end
        bus.rsp_ready_i = 1'b1;
        tick();
        checks++;
        if ({bus.rsp_valid_o, bus.cmd_ready_o, bus.wbm_cyc_o, bus.rsp_dat_o} !== {3'b010, 32'h1111_2222}) begin
            errors++;
            $display("FAIL bp_handshake: got v/r/c=%b%b%b d=%h expected 010 11112222",
                     bus.rsp_valid_o, bus.cmd_ready_o, bus.wbm_cyc_o, bus.rsp_dat_o);
        end
        tick();
        bus.cmd_valid_i = 1'b0;
        checks++;
        if ({bus.wbm_cyc_o, bus.wbm_we_o, bus.wbm_adr_o} !== {2'b11, 32'h0000_2000}) begin
            errors++;
            $display("FAIL bp_second_accept: got c/w=%b%b adr=%h expected 11 00002000",
                     bus.wbm_cyc_o, bus.wbm_we_o, bus.wbm_adr_o);
        end
        run_bus(1, 32'h9999_9999, n);
        checks++;
        if ({bus.rsp_valid_o, bus.rsp_dat_o} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL bp_second_rsp: got v=%b d=%h expected 1 00000000", bus.rsp_valid_o, bus.rsp_dat_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int accepts;
        int rsps;
        accepts = 0;
        rsps = 0;
        bus.rsp_ready_i = 1'b1;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = 32'h0000_0100;
        bus.cmd_sel_i   = 4'hF;
        bus.cmd_valid_i = 1'b1;
        bus.wbm_dat_i   = 32'h0000_0042;
        for (int c = 0; c < 9; c++) begin
            bus.wbm_ack_i = bus.wbm_stb_o;
            if (bus.cmd_ready_o && bus.cmd_valid_i) accepts++;
            if (bus.rsp_valid_o && bus.rsp_ready_i) rsps++;
            tick();
        end
        bus.cmd_valid_i = 1'b0;
        bus.wbm_ack_i   = 1'b0;
        checks++;
        if (accepts !== 3 || rsps !== 3) begin
            errors++;
            $display("FAIL b2b_throughput: got accepts=%0d rsps=%0d expected 3 3", accepts, rsps);
        end
        tick();
    endtask

    task automatic test_reset_mid_bus();
        int n;
        issue(1'b0, 32'h0000_0080, 32'h0, 4'hF);
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid_o, busy, bus.cmd_ready_o} !== 5'b00001) begin
            errors++;
            $display("FAIL rstmid_async: got c/s/v/b/r=%b expected 00001",
                     {bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid_o, busy, bus.cmd_ready_o});
        end
        tick();
        rst = 1'b0;
        tick();
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h5555_5555;
        repeat (2) tick();
        checks++;
        if ({bus.rsp_valid_o, bus.wbm_cyc_o, busy} !== 3'b000) begin
            errors++;
            $display("FAIL stray_ack: got v/c/b=%b expected 000", {bus.rsp_valid_o, bus.wbm_cyc_o, busy});
        end
        bus.wbm_ack_i = 1'b0;
        issue(1'b0, 32'h0000_0044, 32'h0, 4'hF);
        run_bus(2, 32'hCAFE_F00D, n);
        checks++;
        if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o} !== {2'b10, 32'hCAFE_F00D} || n !== 2) begin
            errors++;
            $display("FAIL rstmid_read: got v/e/d=%b%b %h n=%0d expected 10 cafef00d n=2",
                     bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o, n);
        end
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = 32'h0;
        bus.cmd_dat_i   = 32'h0;
        bus.cmd_sel_i   = 4'h0;
        bus.rsp_ready_i = 1'b1;
        bus.wbm_dat_i   = 32'h0;
        bus.wbm_ack_i   = 1'b0;
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_timeout();
        test_ack_on_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_bus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
